// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
// Executes MULT/MULTU/DIV/DIVU in WIDTH+1 cycles (WIDTH iterations plus one
// sign-fix/commit cycle). HI/LO hold the last result and can also be written
// directly through mthi/mtlo while the unit is idle.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        launch an operation (sampled only when idle)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a        multiplicand / dividend; MTHI/MTLO write data
//   src_b        multiplier / divisor
//   mthi, mtlo   write HI / LO from src_a (idle, no start)
//   hi, lo       architectural HI/LO registers
//   busy         operation in progress
//   done         one-cycle pulse when new HI/LO are committed
//   div_by_zero  last accepted divide had a zero divisor
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] a_q, a_d;       // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] b_q, b_d;       // multiplier shift register, or divisor
  logic [PW-1:0]    acc_q, acc_d;   // product accumulator
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             in_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Datapath helpers: operand magnitudes, one shift-add step, one restoring-divide step.
  always_comb begin
    in_signed = ~op[0];
    a_mag     = (in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag     = (in_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    // Upper half plus multiplicand; the carry becomes the new MSB after the right shift.
    mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    // Shift next dividend bit into the remainder; one extra bit holds the trial value.
    div_trial = {rem_q, a_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix   = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
    rem_fix   = sign_a_q ? -rem_q : rem_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = CW'(WIDTH - 1);
          is_div_d = op[1];
          sign_a_d = in_signed & src_a[WIDTH-1];
          sign_b_d = in_signed & src_b[WIDTH-1];
          a_d      = a_mag;
          b_d      = b_mag;
          acc_d    = '0;
          rem_d    = '0;
          dbz_d    = op[1] && (src_b == '0);
        end else begin
          if (mthi) hi_d = src_a;
          if (mtlo) lo_d = src_a;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          rem_d = div_ge ? WIDTH'(div_trial - {1'b0, b_q}) : div_trial[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // A zero divisor yields all-ones quotient; remainder is the signed dividend.
          lo_d = dbz_q ? {WIDTH{1'b1}} : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
